// File: rtl/mode_select.sv
// Push-button mode selector: debounced short presses step through five
// video modes, a long press returns to the first mode.

`ifndef MODE_1080p
`define MODE_1080p 8'h01
`endif
`ifndef MODE_1080i
`define MODE_1080i 8'h02
`endif
`ifndef MODE_720p
`define MODE_720p 8'h03
`endif
`ifndef MODE_480p
`define MODE_480p 8'h04
`endif
`ifndef MODE_480i
`define MODE_480i 8'h05
`endif

module mode_select #(
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button,
  output logic [7:0] mode_out,
  output logic [2:0] mode_index,
  output logic       mode_changed
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(LONG_PRESS_CYCLES) + 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LONG = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  logic [1:0]    sync;
  logic          db_level;
  logic          db_prev;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold;
  logic [HW-1:0] hold_inc;
  logic [2:0]    next_index;
  logic          db_rise;
  logic          db_fall;
  state_t        state;

  always_ff @(posedge clock) begin
    if (reset) sync <= '0;
    else       sync <= {sync[0], button};
  end

  // Any sample that matches the held level restarts the stability count.
  always_ff @(posedge clock) begin
    if (reset) begin
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else if (sync[1] == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_level <= sync[1];
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) db_prev <= 1'b0;
    else       db_prev <= db_level;
  end

  assign db_rise = db_level & ~db_prev;
  assign db_fall = ~db_level & db_prev;

  assign hold_inc = (hold == HOLD_MAX) ? hold : hold + 1'b1;

  // Out-of-range indices fall back to the first mode.
  assign next_index = (mode_index >= 3'd4) ? 3'd0 : mode_index + 3'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      hold         <= '0;
      mode_index   <= 3'd0;
      mode_changed <= 1'b0;
    end else begin
      mode_changed <= 1'b0;
      unique case (state)
        IDLE: begin
          if (db_rise) begin
            state <= PRESSED;
            hold  <= '0;
          end
        end
        PRESSED: begin
          if (db_fall) begin
            state <= IDLE;
            if (hold < HOLD_LONG) begin
              mode_index   <= next_index;
              mode_changed <= 1'b1;
            end
          end else if (db_level) begin
            hold <= hold_inc;
            if (hold_inc == HOLD_LONG) begin
              state <= WAIT_RELEASE;
              if (mode_index != 3'd0) begin
                mode_index   <= 3'd0;
                mode_changed <= 1'b1;
              end
            end
          end
        end
        WAIT_RELEASE: begin
          if (db_fall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mode_out = `MODE_1080p;
    case (mode_index)
      3'd0:    mode_out = `MODE_1080p;
      3'd1:    mode_out = `MODE_1080i;
      3'd2:    mode_out = `MODE_720p;
      3'd3:    mode_out = `MODE_480p;
      3'd4:    mode_out = `MODE_480i;
      default: mode_out = `MODE_1080p;
    endcase
  end

endmodule

// File: tb/tb_mode_select.sv
// Bench for mode_select: directed press scenarios plus random button runs,
// checked every cycle against a window-based behavioural model.

`ifndef MODE_1080p
`define MODE_1080p 8'h01
`endif
`ifndef MODE_1080i
`define MODE_1080i 8'h02
`endif
`ifndef MODE_720p
`define MODE_720p 8'h03
`endif
`ifndef MODE_480p
`define MODE_480p 8'h04
`endif
`ifndef MODE_480i
`define MODE_480i 8'h05
`endif

module tb_mode_select;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       button = 1'b0;
  logic [7:0] mode_out;
  logic [2:0] mode_index;
  logic       mode_changed;

  int n_cmp = 0;
  int n_err = 0;

  int bq[$] = '{0, 0};
  int win[$];
  int lv = 0;
  int lv_prev = 0;
  int st = 0;
  int t_rise = 0;
  int idx = 0;
  int chg = 0;
  int cycle = 0;
  int last_pulse = -1;
  int n_pulse = 0;

  mode_select #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .button      (button),
    .mode_out    (mode_out),
    .mode_index  (mode_index),
    .mode_changed(mode_changed)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               tag, cycle, got, exp);
    end
  endtask

  function automatic logic [7:0] code(input int i);
    case (i)
      0: return `MODE_1080p;
      1: return `MODE_1080i;
      2: return `MODE_720p;
      3: return `MODE_480p;
      4: return `MODE_480i;
      default: return `MODE_1080p;
    endcase
  endfunction

  // Model: level flips once the last DEB synchronised samples all differ.
  task automatic model_edge(input int b, input int r);
    int seen;
    int lp;
    int lpp;
    int all_diff;
    cycle++;
    if (r != 0) begin
      bq = '{0, 0};
      win.delete();
      lv = 0;
      lv_prev = 0;
      st = 0;
      idx = 0;
      chg = 0;
      return;
    end
    lp = lv;
    lpp = lv_prev;
    chg = 0;
    if (st == 0) begin
      if (lp == 1 && lpp == 0) begin
        st = 1;
        t_rise = cycle;
      end
    end else if (st == 1) begin
      if (lp == 0 && lpp == 1) begin
        idx = (idx + 1) % 5;
        chg = 1;
        st = 0;
      end else if (lp == 1 && cycle - t_rise == LONG) begin
        if (idx != 0) chg = 1;
        idx = 0;
        st = 2;
      end
    end else begin
      if (lp == 0 && lpp == 1) st = 0;
    end
    seen = bq[0];
    bq.pop_front();
    bq.push_back(b);
    win.push_back(seen);
    if (win.size() > DEB) win.pop_front();
    if (win.size() == DEB) begin
      all_diff = 1;
      foreach (win[i]) if (win[i] == lv) all_diff = 0;
      if (all_diff != 0) lv = 1 - lv;
    end
    lv_prev = lp;
  endtask

  task automatic step(input int b, input int r);
    button = b[0];
    reset = r[0];
    @(posedge clock);
    model_edge(b, r);
    @(negedge clock);
    chk("mode_index", 32'(mode_index), 32'(idx));
    chk("mode_out", 32'(mode_out), 32'(code(idx)));
    chk("mode_changed", 32'(mode_changed), 32'(chg));
    if (mode_changed === 1'b1) begin
      last_pulse = cycle;
      n_pulse++;
    end
  endtask

  task automatic press(input int h);
    repeat (h) step(1, 0);
    repeat (12) step(0, 0);
  endtask

  initial begin
    int rel;
    int b;
    int len;
    repeat (3) step(0, 1);

    repeat (10) step(0, 0);
    chk("idle_index", 32'(mode_index), 32'd0);
    chk("idle_pulses", 32'(n_pulse), 32'd0);

    repeat (10) step(1, 0);
    rel = cycle;
    last_pulse = -1;
    repeat (12) step(0, 0);
    chk("short_latency", 32'(last_pulse - rel - 1), 32'd6);
    chk("short_index", 32'(mode_index), 32'd1);
    chk("short_out", 32'(mode_out), 32'(`MODE_1080i));

    step(0, 1);
    n_pulse = 0;
    for (int i = 1; i <= 5; i++) begin
      press(10);
      chk("cycle_index", 32'(mode_index), 32'(i % 5));
    end
    chk("cycle_pulses", 32'(n_pulse), 32'd5);
    chk("cycle_out", 32'(mode_out), 32'(`MODE_1080p));

    n_pulse = 0;
    repeat (10) begin
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    end
    repeat (10) step(0, 0);
    chk("bounce_pulses", 32'(n_pulse), 32'd0);
    chk("bounce_index", 32'(mode_index), 32'd0);

    repeat (3) press(10);
    chk("pre_long_index", 32'(mode_index), 32'd3);
    n_pulse = 0;
    press(40);
    chk("long_index", 32'(mode_index), 32'd0);
    chk("long_pulses", 32'(n_pulse), 32'd1);
    n_pulse = 0;
    press(40);
    chk("long_at0_pulses", 32'(n_pulse), 32'd0);

    step(0, 1);
    n_pulse = 0;
    repeat (10) step(1, 0);
    step(1, 1);
    repeat (30) step(1, 0);
    repeat (12) step(0, 0);
    chk("rst_press_index", 32'(mode_index), 32'd0);
    chk("rst_press_pulses", 32'(n_pulse), 32'd0);
    press(10);
    chk("after_rst_index", 32'(mode_index), 32'd1);

    for (int h = 17; h <= 27; h++) press(h);

    repeat (300) begin
      if ($urandom_range(0, 39) == 0) begin
        repeat ($urandom_range(1, 2)) step(int'($urandom_range(0, 1)), 1);
      end
      b = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 30));
      repeat (len) step(b, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
